// File: rtl/var_clk_meter.sv
// Measures the period of a slow divided clock in clock_50MHz cycles and recovers its decade code.
// Optional VAR_CLK_METER_CONFIRM_EN: require two consecutive equal classifications before sel_out moves.
module var_clk_meter #(
    parameter int CNT_W   = 26,
    parameter int TIMEOUT = 67108863
) (
    input  logic             clock_50MHz,
    input  logic             reset,
    input  logic             clk_in,
    output logic [2:0]       sel_out,
    output logic             valid,
    output logic             update,
    output logic             stalled,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [1:0] {WAIT_FIRST, ARMED, CONFIRM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic             sync1, sync2, dly;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       cls;
`ifdef VAR_CLK_METER_CONFIRM_EN
    logic [2:0]       cand;
`endif

    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        logic [31:0] v;
        v = 32'(p);
        if      (v < 32'd16)       classify = 3'b111;
        else if (v < 32'd160)      classify = 3'b110;
        else if (v < 32'd1600)     classify = 3'b101;
        else if (v < 32'd16000)    classify = 3'b100;
        else if (v < 32'd160000)   classify = 3'b011;
        else if (v < 32'd1600000)  classify = 3'b010;
        else if (v < 32'd16000000) classify = 3'b001;
        else                       classify = 3'b000;
    endfunction

    assign rise = sync2 & ~dly;
    assign cls  = classify(cnt);

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            state   <= WAIT_FIRST;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            dly     <= 1'b0;
            cnt     <= '0;
            sel_out <= 3'b000;
            valid   <= 1'b0;
            update  <= 1'b0;
            stalled <= 1'b0;
            period  <= '0;
`ifdef VAR_CLK_METER_CONFIRM_EN
            cand    <= 3'b000;
`endif
        end else begin
            sync1  <= clk_in;
            sync2  <= sync1;
            dly    <= sync2;
            update <= 1'b0;

            // saturate rather than wrap so a stopped clock never aliases to a short period
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (rise) begin
                stalled <= 1'b0;
                case (state)
                    WAIT_FIRST: state <= ARMED;
                    ARMED: begin
                        period <= cnt;
`ifdef VAR_CLK_METER_CONFIRM_EN
                        cand  <= cls;
                        state <= CONFIRM;
`else
                        sel_out <= cls;
                        valid   <= 1'b1;
                        update  <= !valid || (sel_out != cls);
`endif
                    end
`ifdef VAR_CLK_METER_CONFIRM_EN
                    CONFIRM: begin
                        period <= cnt;
                        if (cls == cand) begin
                            sel_out <= cls;
                            valid   <= 1'b1;
                            update  <= !valid || (sel_out != cls);
                        end else begin
                            cand <= cls;
                        end
                    end
`endif
                    default: state <= WAIT_FIRST;
                endcase
            end else if (state != WAIT_FIRST && cnt == CNT_MAX) begin
                stalled <= 1'b1;
                valid   <= 1'b0;
                update  <= valid;
                state   <= WAIT_FIRST;
            end
        end
    end

endmodule

// File: tb/tb_var_clk_meter.sv
// Randomized self-checking bench for var_clk_meter against an edge-level behavioural model.
module tb_var_clk_meter;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 4000;
`ifdef VAR_CLK_METER_CONFIRM_EN
    localparam bit CONF = 1'b1;
`else
    localparam bit CONF = 1'b0;
`endif

    logic             clock_50MHz = 1'b0;
    logic             reset;
    logic             clk_in;
    logic [2:0]       sel_out;
    logic             valid;
    logic             update;
    logic             stalled;
    logic [CNT_W-1:0] period;

    var_clk_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_50MHz(clock_50MHz),
        .reset      (reset),
        .clk_in     (clk_in),
        .sel_out    (sel_out),
        .valid      (valid),
        .update     (update),
        .stalled    (stalled),
        .period     (period)
    );

    always #10 clock_50MHz = ~clock_50MHz;

    int errs = 0;
    int checks = 0;
    int upd_cnt = 0;

    always @(negedge clock_50MHz) if (update) upd_cnt <= upd_cnt + 1;

    // model: outputs follow from the list of edge spacings in the current run
    int m_period, m_sel, m_valid, m_stalled, m_upd;
    int run_edges, prev_cls, last_p;

    function automatic int ref_cls(input int p);
        int thr;
        int c;
        thr = 16;
        c = 7;
        while (c > 0 && p >= thr) begin
            thr = thr * 10;
            c--;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_period = 0; m_sel = 0; m_valid = 0; m_stalled = 0;
        run_edges = 0; prev_cls = -1; last_p = 0;
    endtask

    task automatic model_edge();
        int c;
        bit ld;
        if (run_edges > 0) begin
            m_period = last_p;
            c = ref_cls(last_p);
            ld = CONF ? (run_edges >= 2 && c == prev_cls) : 1'b1;
            prev_cls = c;
            if (ld) begin
                if (m_valid == 0 || m_sel != c) m_upd++;
                m_sel = c;
                m_valid = 1;
            end
        end
        m_stalled = 0;
        run_edges++;
    endtask

    // one clk_in period of p system cycles, then compare against the model
    task automatic pulse(input int p, input string tag);
        model_edge();
        clk_in = 1'b1;
        repeat (p / 2) @(negedge clock_50MHz);
        clk_in = 1'b0;
        repeat (p - p / 2) @(negedge clock_50MHz);
        #1;
        checks += 5;
        if (int'(period) !== m_period) begin
            errs++; $display("FAIL %s period got %0d want %0d", tag, period, m_period);
        end
        if (int'(sel_out) !== m_sel) begin
            errs++; $display("FAIL %s sel_out got %0d want %0d", tag, sel_out, m_sel);
        end
        if (int'(valid) !== m_valid) begin
            errs++; $display("FAIL %s valid got %0d want %0d", tag, valid, m_valid);
        end
        if (int'(stalled) !== m_stalled) begin
            errs++; $display("FAIL %s stalled got %0d want %0d", tag, stalled, m_stalled);
        end
        if (upd_cnt !== m_upd) begin
            errs++; $display("FAIL %s update_count got %0d want %0d", tag, upd_cnt, m_upd);
        end
        last_p = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_in = 1'b0;
        m_upd = 0;
        model_reset();
        repeat (3) @(negedge clock_50MHz);
        #1;
        checks++;
        if ({sel_out, valid, update, stalled, period} !== '0) begin
            errs++; $display("FAIL reset_values got %b want 0", {sel_out, valid, update, stalled, period});
        end
        @(negedge clock_50MHz);
        reset = 1'b0;
    endtask

    task automatic test_10mhz();
        for (int i = 0; i < 5; i++) pulse(5, "10mhz");
    endtask

    task automatic test_boundary();
        int bnd[6] = '{15, 16, 159, 160, 1599, 1600};
        for (int i = 0; i < 6; i++) begin
            pulse(bnd[i], "boundary");
            pulse(bnd[i], "boundary");
            pulse(bnd[i], "boundary");
        end
    endtask

    task automatic test_switch_glitch();
        for (int i = 0; i < 3; i++) pulse(1000, "switch_a");
        for (int i = 0; i < 3; i++) pulse(2000, "switch_b");
        pulse(1000, "glitch");
        pulse(2000, "glitch");
        pulse(2000, "glitch");
    endtask

    task automatic test_timeout_edge();
        pulse(TIMEOUT, "rise_at_timeout");
        pulse(TIMEOUT, "rise_at_timeout");
        pulse(100, "rise_at_timeout");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) pulse(50, "pre_stall");
        repeat (TIMEOUT + 2 - last_p) @(negedge clock_50MHz);
        #1;
        checks++;
        if (stalled !== 1'b0) begin
            errs++; $display("FAIL stall_early stalled got %0d want 0", stalled);
        end
        @(negedge clock_50MHz);
        #1;
        if (m_valid != 0) m_upd++;
        m_valid = 0;
        m_stalled = 1;
        run_edges = 0;
        checks += 4;
        if (stalled !== 1'b1) begin
            errs++; $display("FAIL stall stalled got %0d want 1", stalled);
        end
        if (valid !== 1'b0) begin
            errs++; $display("FAIL stall valid got %0d want 0", valid);
        end
        if (int'(sel_out) !== m_sel) begin
            errs++; $display("FAIL stall sel_hold got %0d want %0d", sel_out, m_sel);
        end
        if (upd_cnt !== m_upd) begin
            errs++; $display("FAIL stall update_count got %0d want %0d", upd_cnt, m_upd);
        end
        for (int i = 0; i < 4; i++) pulse(50, "restart");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) pulse(50, "pre_reset");
        reset = 1'b1;
        #1;
        checks++;
        if ({sel_out, valid, update, stalled, period} !== '0) begin
            errs++; $display("FAIL reset_mid got %b want 0", {sel_out, valid, update, stalled, period});
        end
        model_reset();
        @(negedge clock_50MHz);
        reset = 1'b0;
        @(negedge clock_50MHz);
        for (int i = 0; i < 4; i++) pulse(50, "post_reset");
    endtask

    task automatic test_random();
        int p;
        p = 5;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: p = $urandom_range(5, 15);
                    1: p = $urandom_range(16, 159);
                    2: p = $urandom_range(160, 1599);
                    default: p = $urandom_range(1600, 3000);
                endcase
            end
            pulse(p, "random");
        end
    endtask

    initial begin
        test_reset();
        test_10mhz();
        test_boundary();
        test_switch_glitch();
        test_timeout_edge();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
